// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync
// Purpose  : Parametrised single-clock show-ahead FIFO on register storage.
//            Tracks occupancy, raises an almost-full warning, and keeps sticky
//            overflow/underflow flags. clr flushes synchronously; r resets
//            all control state asynchronously.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     c,
  input  logic                     r,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int                  c_ADDR_W   = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0]   c_FULL_CNT = (c_ADDR_W + 1)'(DEPTH);
  localparam logic [c_ADDR_W:0]   c_AF_CNT   = (c_ADDR_W + 1)'(AF_LEVEL);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wptr;
  logic [c_ADDR_W-1:0] r_rptr;
  logic [c_ADDR_W:0]   r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_mem_we;

  // Status is derived purely from the registered occupancy.
  assign w_full   = (r_count == c_FULL_CNT);
  assign w_empty  = (r_count == '0);

  // Acceptance is judged on the pre-edge state; clr discards both requests.
  assign w_push   = wr_en && !w_full;
  assign w_pop    = rd_en && !w_empty;
  assign w_mem_we = w_push && !clr;

  // Storage carries no reset; only accepted, non-flushed pushes write it.
  always_ff @(posedge c) begin
    if (w_mem_we) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky error flags; clr overrides any request.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ADDR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ADDR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (c_ADDR_W + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (c_ADDR_W + 1)'(1);
      end
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Show-ahead head word, forced to zero when nothing is stored.
  assign rd_data     = w_empty ? '0 : r_mem[r_rptr];
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= c_AF_CNT);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync
// Purpose  : Scoreboard bench for fifo_sync (WIDTH=16, DEPTH=4, AF_LEVEL=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync;

  localparam int c_WIDTH = 16;
  localparam int c_DEPTH = 4;
  localparam int c_AF    = 3;

  logic               c;
  logic               r;
  logic               clr;
  logic               wr_en;
  logic [c_WIDTH-1:0] wr_data;
  logic               rd_en;
  logic [c_WIDTH-1:0] rd_data;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic [2:0]         count;
  logic               overflow;
  logic               underflow;

  fifo_sync #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .AF_LEVEL(c_AF)) dut (
    .c(c), .r(r), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  int checks   = 0;
  int failures = 0;

  logic [c_WIDTH-1:0] exp_q[$];
  int                 mcount = 0;
  logic               mov    = 1'b0;
  logic               mun    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Full status comparison against the bench model.
  task automatic chk(input string tag);
    check({tag, ".count"},       32'(count),       32'(mcount));
    check({tag, ".empty"},       32'(empty),       32'(mcount == 0));
    check({tag, ".full"},        32'(full),        32'(mcount == c_DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(mcount >= c_AF));
    check({tag, ".overflow"},    32'(overflow),    32'(mov));
    check({tag, ".underflow"},   32'(underflow),   32'(mun));
    if (mcount == 0) check({tag, ".head"}, 32'(rd_data), 32'h0);
    else             check({tag, ".head"}, 32'(rd_data), 32'(exp_q[0]));
  endtask

  // Called at posedge+1; holds the request over one edge, then idles.
  task automatic op(input logic we, input logic [c_WIDTH-1:0] wd, input logic re);
    bit push_ok;
    bit pop_ok;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    push_ok = we && (mcount < c_DEPTH);
    pop_ok  = re && (mcount > 0);
    if (we && mcount == c_DEPTH) mov = 1'b1;
    if (re && mcount == 0)       mun = 1'b1;
    if (push_ok) exp_q.push_back(wd);
    if (push_ok && !pop_ok) mcount++;
    if (pop_ok && !push_ok) mcount--;
    @(posedge c); #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic op_clr(input logic we, input logic [c_WIDTH-1:0] wd);
    clr     = 1'b1;
    wr_en   = we;
    wr_data = wd;
    exp_q.delete();
    mcount = 0;
    mov    = 1'b0;
    mun    = 1'b0;
    @(posedge c); #1;
    clr   = 1'b0;
    wr_en = 1'b0;
  endtask

  // Monitor: every accepted pop must present the oldest expected word.
  always @(negedge c) begin
    if (r && !clr && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_data: got 0x%0h expected no data (queue empty)", rd_data);
      end else begin
        check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    r       = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    #12;
    chk("reset");
    r = 1'b1;
    @(posedge c); #1;
    chk("idle");

    // Fill, with almost_full expected from count 3.
    op(1'b1, 16'h1111, 1'b0); chk("fill1");
    op(1'b1, 16'h2222, 1'b0); chk("fill2");
    op(1'b1, 16'h3333, 1'b0); chk("fill3");
    check("af_at_3", 32'(almost_full), 32'h1);
    op(1'b1, 16'h4444, 1'b0); chk("fill4");
    check("full_at_4", 32'(full), 32'h1);

    // Push while full.
    op(1'b1, 16'h5555, 1'b0); chk("ovf");
    check("ovf_head", 32'(rd_data), 32'h1111);
    check("ovf_count", 32'(count), 32'h4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 16'h0, 1'b1); chk("drain");
    end
    check("drained_empty", 32'(empty), 32'h1);

    // Pop while empty, then flush both flags.
    op(1'b0, 16'h0, 1'b1); chk("unf");
    check("unf_flag", 32'(underflow), 32'h1);
    op_clr(1'b0, 16'h0); chk("clr_flags");

    // Steady push+pop at count 2 across pointer wrap.
    op(1'b1, 16'hA0A0, 1'b0);
    op(1'b1, 16'hA1A1, 1'b0); chk("pre_stream");
    for (int i = 0; i < 10; i++) begin
      op(1'b1, 16'hB000 + 16'(i), 1'b1); chk("stream");
    end
    op(1'b0, 16'h0, 1'b1);
    op(1'b0, 16'h0, 1'b1); chk("stream_drain");

    // Simultaneous push+pop when empty: push only, underflow set.
    op(1'b1, 16'hC0C0, 1'b1); chk("both_empty");
    check("both_empty_head", 32'(rd_data), 32'hC0C0);
    op(1'b0, 16'h0, 1'b1); chk("both_empty_pop");

    // Simultaneous push+pop when full: pop only, overflow set.
    op_clr(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) op(1'b1, 16'hD000 + 16'(i), 1'b0);
    op(1'b1, 16'hEEEE, 1'b1); chk("both_full");
    check("both_full_count", 32'(count), 32'h3);
    op_clr(1'b0, 16'h0);

    // Flush with a concurrent push at count 3.
    for (int i = 0; i < 3; i++) op(1'b1, 16'hF000 + 16'(i), 1'b0);
    chk("pre_flush");
    op_clr(1'b1, 16'hDEAD); chk("flush");
    check("flush_count", 32'(count), 32'h0);
    op(1'b0, 16'h0, 1'b0); chk("flush_idle");

    // Asynchronous reset between edges at count 2.
    op(1'b1, 16'h7777, 1'b0);
    op(1'b1, 16'h8888, 1'b0); chk("pre_areset");
    #2 r = 1'b0;
    #1;
    exp_q.delete();
    mcount = 0;
    mov    = 1'b0;
    mun    = 1'b0;
    check("areset_empty", 32'(empty), 32'h1);
    chk("areset");
    #2 r = 1'b1;
    @(posedge c); #1;
    chk("post_areset");
    op(1'b1, 16'h9999, 1'b0); chk("resume");
    op(1'b0, 16'h0, 1'b1); chk("resume_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync.md
# fifo_sync

Parametrised synchronous show-ahead FIFO built from enable-gated register storage. It is the next-generation storage utility: generalised in width and depth, with occupancy tracking, almost-full warning, sticky error flags and synchronous flush. It is used for buffering between CPU pipeline stages and between the CPU and memory-mapped peripherals, all on one clock domain.

## Interface
- WIDTH, 16, data width in bits.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; valid range 1..DEPTH.
- c  input  1  clock; all state updates on the rising edge.
- r  input  1  reset, asynchronous, active-low; clears all control state immediately.
- clr  input  1  synchronous flush, active-high.
- wr_en  input  1  push request.
- wr_data  input  WIDTH  push data.
- rd_en  input  1  pop request.
- rd_data  output  WIDTH  head entry (show-ahead); 0 when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

## Operation
- Storage is an array of DEPTH WIDTH-bit registers. The array is not reset. The write pointer, read pointer, count and flags are reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push is accepted iff wr_en && !full. An accepted push writes mem[wptr] <= wr_data and increments wptr.
- Pop is accepted iff rd_en && !empty. An accepted pop increments rptr.
- count update per cycle:
  - +1 for push only.
  - -1 for pop only.
  - unchanged when both or neither are accepted.
- Simultaneous push and pop:
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: the pop is accepted, the push is rejected, and overflow is set. Acceptance is judged on the pre-edge state.
  - Empty: the push is accepted, the pop is rejected, and underflow is set.
- rd_data is driven combinationally from mem[rptr] when !empty, and is 0 when empty. There is no bypass: a word pushed into an empty FIFO is visible one cycle later.
- overflow is set on wr_en && full; underflow is set on rd_en && empty. Both hold until clr or reset.
- clr has priority over everything:
  - Pointers, count, overflow and underflow go to 0.
  - Any push or pop in the same cycle is discarded.
  - Storage contents are left untouched.
- Reset values: count=0, empty=1, full=0, almost_full=0 (because AF_LEVEL >= 1), overflow=0, underflow=0, rd_data=0.
- Reset asserted mid-operation: the FIFO empties immediately and asynchronously. Contents are lost logically. Normal operation resumes on the first rising edge after r deasserts.

## Timing
- Push to visible at head (empty FIFO): 1 cycle; empty falls on the same edge.
- Pop to next head visible: same edge. rd_data changes combinationally after the edge that advances rptr.
- full, empty, almost_full and count are registered-state-derived. They change only on a clock edge, or asynchronously on reset.
- Error flags rise on the edge that samples the offending request.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Reset, then idle: r low, then high -> empty=1, count=0, rd_data=0x0000, overflow=underflow=0.
- Fill and drain (WIDTH=16, DEPTH=4): push 0x1111, 0x2222, 0x3333, 0x4444 -> full=1, count=4, almost_full=1 from count 3. Pop 4 times -> rd_data reads 0x1111..0x4444 in order, then empty=1.
- Overflow and underflow:
  - Push 0x5555 while full -> overflow=1, count stays 4, head stays 0x1111.
  - Pop while empty -> underflow=1, count stays 0.
  - clr -> both flags 0.
- Simultaneous push and pop:
  - At count=2: count stays 2 and order is preserved across pointer wrap; run 10 cycles continuous.
  - When empty: count goes to 1, underflow=1, and the data appears the next cycle.
- Flush and async reset mid-stream:
  - clr with wr_en=1 at count=3 -> count=0 next cycle and the push is discarded.
  - r pulsed low between edges at count=2 -> empty=1 immediately, without waiting for a clock edge.
